// File: rtl/output_deskewer.sv
// Realigns skewed systolic-array column outputs into row-parallel words and buffers them in a small FIFO.
// Optional build macro OUTPUT_DESKEWER_DROP_CNT_EN adds a saturating drop_count output that drives overflow.
module output_deskewer #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable_in,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data_skewed_in,
    input  logic                                  valid_skewed_in,
    input  logic                                  ready_in,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data_out,
    output logic                                  valid_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count,
    output logic                                  overflow
`ifdef OUTPUT_DESKEWER_DROP_CNT_EN
    ,
    output logic [7:0]                            drop_count
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] aligned_data;
    logic                                  aligned_valid;

    // Column i needs MATRIX_SIZE-1-i stages; the last column passes straight through.
    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_col
        localparam int D = MATRIX_SIZE - 1 - i;
        if (D == 0) begin : g_thru
            assign aligned_data[i] = data_skewed_in[i];
        end else begin : g_dl
            logic [DATA_SIZE-1:0] stage [D];
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int k = 0; k < D; k++) stage[k] <= '0;
                end else if (enable_in) begin
                    stage[0] <= data_skewed_in[i];
                    for (int k = 1; k < D; k++) stage[k] <= stage[k-1];
                end
            end
            assign aligned_data[i] = stage[D-1];
        end
    end

    if (MATRIX_SIZE == 1) begin : g_vthru
        assign aligned_valid = valid_skewed_in;
    end else begin : g_vdl
        logic vstage [MATRIX_SIZE-1];
        always_ff @(posedge clk) begin
            if (!reset) begin
                for (int k = 0; k < MATRIX_SIZE-1; k++) vstage[k] <= 1'b0;
            end else if (enable_in) begin
                vstage[0] <= valid_skewed_in;
                for (int k = 1; k < MATRIX_SIZE-1; k++) vstage[k] <= vstage[k-1];
            end
        end
        assign aligned_valid = vstage[MATRIX_SIZE-2];
    end

    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic          drop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (count == CW'(FIFO_DEPTH));
    assign valid_out = (count != '0);
    assign push      = aligned_valid & enable_in;
    assign pop       = valid_out & ready_in;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the row.
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;

    assign fifo_count = count;
    assign data_out   = valid_out ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset && wr_en) mem[wr_ptr] <= aligned_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= next_ptr(wr_ptr);
            if (pop)   rd_ptr <= next_ptr(rd_ptr);
            unique case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef OUTPUT_DESKEWER_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_count <= 8'd0;
        end else if (drop && drop_count != 8'hff) begin
            drop_count <= drop_count + 8'd1;
        end
    end
    assign overflow = (drop_count != 8'd0);
`else
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_output_deskewer.sv
// Self-checking bench for output_deskewer: directed test-plan scenarios plus a randomized phase,
// compared every cycle against a row-assembly / bounded-queue reference model.
module tb_output_deskewer;
    localparam int M  = 3;
    localparam int DW = 8;
    localparam int FD = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable_in;
    logic               valid_skewed_in;
    logic               ready_in;
    logic [M-1:0][DW-1:0] data_skewed_in;
    logic [M-1:0][DW-1:0] data_out;
    logic               valid_out;
    logic [1:0]         fifo_count;
    logic               overflow;
`ifdef OUTPUT_DESKEWER_DROP_CNT_EN
    logic [7:0]         drop_count;
`endif

    output_deskewer #(.MATRIX_SIZE(M), .DATA_SIZE(DW), .FIFO_DEPTH(FD)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable_in       (enable_in),
        .data_skewed_in  (data_skewed_in),
        .valid_skewed_in (valid_skewed_in),
        .ready_in        (ready_in),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .fifo_count      (fifo_count),
        .overflow        (overflow)
`ifdef OUTPUT_DESKEWER_DROP_CNT_EN
        ,
        .drop_count      (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: rows are assembled from the column values seen on the
    // last three enabled edges, then held in a bounded FIFO queue.
    logic [23:0] q[$];
    bit          hv[$];
    logic [23:0] hc[$];
    bit          m_ovf = 0;
    int          m_drops = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst_n, input logic en, input logic v,
                              input logic rdy, input logic [23:0] cols);
        bit          do_pop;
        bit          do_push;
        logic [23:0] row;
        do_pop  = 0;
        do_push = 0;
        row     = '0;
        if (!rst_n) begin
            q.delete();
            hv.delete();
            hc.delete();
            m_ovf   = 0;
            m_drops = 0;
        end else begin
            do_pop = (q.size() > 0) && rdy;
            if (en) begin
                hv.push_front(v);
                hc.push_front(cols);
                if (hv.size() > 3) begin
                    void'(hv.pop_back());
                    void'(hc.pop_back());
                end
                if (hv.size() == 3 && hv[2]) begin
                    do_push = 1;
                    row = {hc[0][23:16], hc[1][15:8], hc[2][7:0]};
                end
            end
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                if (q.size() < FD) q.push_back(row);
                else begin
                    m_ovf = 1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [23:0] ed;
        ed = (q.size() != 0) ? q[0] : 24'h0;
        chk("valid_out", {31'b0, valid_out}, {31'b0, q.size() != 0});
        chk("data_out", {8'b0, data_out}, {8'b0, ed});
        chk("fifo_count", {30'b0, fifo_count}, q.size());
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
`ifdef OUTPUT_DESKEWER_DROP_CNT_EN
        chk("drop_count", {24'b0, drop_count}, m_drops);
`endif
    endtask

    task automatic step(input logic rst_n, input logic en, input logic v, input logic rdy,
                        input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
        reset           = rst_n;
        enable_in       = en;
        valid_skewed_in = v;
        ready_in        = rdy;
        data_skewed_in  = {c2, c1, c0};
        @(posedge clk);
        model_edge(rst_n, en, v, rdy, {c2, c1, c0});
        #1;
        check_all();
    endtask

    function automatic logic [7:0] rnd8();
        return 8'($urandom);
    endfunction

    // Streams n back-to-back rows; row r column i carries base + 3*r + i.
    task automatic stream(input int n, input logic rdy, input logic [7:0] base);
        logic [7:0] c0, c1, c2;
        for (int k = 0; k < n + 2; k++) begin
            c0 = (k < n) ? base + 8'(3*k) : rnd8();
            c1 = (k >= 1 && k - 1 < n) ? base + 8'(3*(k-1) + 1) : rnd8();
            c2 = (k >= 2 && k - 2 < n) ? base + 8'(3*(k-2) + 2) : rnd8();
            step(1, 1, k < n, rdy, c0, c1, c2);
            if (rdy) chk("s3_count_le1", {31'b0, fifo_count <= 2'd1}, 32'd1);
        end
    endtask

    initial begin
        logic [7:0] r1, r2;

        // 1. reset with garbage inputs
        step(0, 1'($urandom), 1, 1'($urandom), rnd8(), rnd8(), rnd8());
        step(0, 1'($urandom), 1, 1'($urandom), rnd8(), rnd8(), rnd8());
        chk("s1_valid", {31'b0, valid_out}, 32'd0);
        chk("s1_data", {8'b0, data_out}, 32'd0);
        chk("s1_count", {30'b0, fifo_count}, 32'd0);
        chk("s1_ovf", {31'b0, overflow}, 32'd0);

        // 2. single row
        step(1, 1, 1, 1, 8'h11, rnd8(), rnd8());
        step(1, 1, 0, 1, rnd8(), 8'h22, rnd8());
        step(1, 1, 0, 1, rnd8(), rnd8(), 8'h33);
        chk("s2_valid", {31'b0, valid_out}, 32'd1);
        chk("s2_data", {8'b0, data_out}, 32'h332211);
        step(1, 1, 0, 1, rnd8(), rnd8(), rnd8());
        chk("s2_valid_drop", {31'b0, valid_out}, 32'd0);

        // 3. streaming three rows
        stream(3, 1, 8'h80);
        step(1, 1, 0, 1, rnd8(), rnd8(), rnd8());

        // 4. backpressure and overflow
        stream(3, 0, 8'h40);
        step(1, 1, 0, 0, rnd8(), rnd8(), rnd8());
        chk("s4_count", {30'b0, fifo_count}, 32'd2);
        chk("s4_ovf", {31'b0, overflow}, 32'd1);
        chk("s4_head0", {8'b0, data_out}, 32'h424140);
        step(1, 1, 0, 1, rnd8(), rnd8(), rnd8());
        chk("s4_head1", {8'b0, data_out}, 32'h454443);
        step(1, 1, 0, 1, rnd8(), rnd8(), rnd8());
        chk("s4_empty", {31'b0, valid_out}, 32'd0);
        chk("s4_ovf_sticky", {31'b0, overflow}, 32'd1);
`ifdef OUTPUT_DESKEWER_DROP_CNT_EN
        chk("s4_drops", {24'b0, drop_count}, 32'd1);
`endif
        step(0, 1, 0, 1, rnd8(), rnd8(), rnd8());

        // 5. enable stall with held inputs
        r1 = rnd8();
        r2 = rnd8();
        step(1, 1, 1, 1, 8'h11, r1, r2);
        step(1, 0, 1, 1, 8'h11, r1, r2);
        step(1, 0, 1, 1, 8'h11, r1, r2);
        step(1, 1, 0, 1, rnd8(), 8'h22, rnd8());
        step(1, 1, 0, 1, rnd8(), rnd8(), 8'h33);
        chk("s5_valid", {31'b0, valid_out}, 32'd1);
        chk("s5_data", {8'b0, data_out}, 32'h332211);
        step(1, 1, 0, 1, rnd8(), rnd8(), rnd8());

        // 6. reset mid-flight
        step(1, 1, 1, 1, 8'h5a, rnd8(), rnd8());
        step(0, 1, 1, 1, rnd8(), rnd8(), rnd8());
        for (int k = 0; k < 10; k++) begin
            step(1, 1, 0, 1, rnd8(), rnd8(), rnd8());
            chk("s6_no_row", {31'b0, valid_out}, 32'd0);
        end

        // randomized traffic with occasional resets and stalls
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 79) != 0, $urandom_range(0, 3) != 0,
                 1'($urandom), (k % 100 < 60) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0),
                 rnd8(), rnd8(), rnd8());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
